// File: rtl/fp_conv_pkg.sv
// Shared widths, constants and FSM encoding for the 12-bit to 8-bit float converter.
package fp_conv_pkg;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned EXP_W  = 3;

    localparam logic [EXP_W-1:0]  EXP_MAX = 3'd7;
    localparam logic [DATA_W-1:0] MAG_SAT = 12'h7FF;
    localparam logic [DATA_W-1:0] NEG_MIN = 12'h800;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        SCAN,
        DONE
    } state_t;

endpackage

// File: rtl/magnitude_converter.sv
// Combinational two's-complement to sign/magnitude, with optional saturation of the most negative code.
module magnitude_converter
    import fp_conv_pkg::*;
#(
    parameter bit SAT_NEG = 1'b1
) (
    input  logic [DATA_W-1:0] i_data,
    output logic              o_sign_c,
    output logic [DATA_W-1:0] o_mag_c,
    output logic              o_sat_c,
    output logic              o_is_min_c
);

    always_comb begin
        o_sign_c   = i_data[DATA_W-1];
        o_is_min_c = (i_data == NEG_MIN);
        o_sat_c    = 1'b0;
        o_mag_c    = i_data;
        // -2048 has no positive 12-bit twin: clamp it, or pass 0x800 through unsigned
        if (o_is_min_c) begin
            if (SAT_NEG) begin
                o_mag_c = MAG_SAT;
                o_sat_c = 1'b1;
            end
        end else if (i_data[DATA_W-1]) begin
            o_mag_c = DATA_W'(~i_data + 1'b1);
        end
    end

endmodule

// File: rtl/exponent_scanner.sv
// Captures a sample, converts it to sign/magnitude and finds the exponent by a
// serial leading-one scan, one bit per clock, presenting the result on valid/ready.
module exponent_scanner
    import fp_conv_pkg::*;
#(
    parameter bit SAT_NEG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_sign,
    output logic [DATA_W-1:0] out_mag,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_sat,
    output logic              out_valid,
    input  logic              out_ready
);

    state_t              r_state;
    logic [DATA_W-1:0]   r_data;
    logic                r_sign;
    logic [DATA_W-1:0]   r_mag;
    logic                r_sat;
    logic [DATA_W-2:0]   r_shreg;
    logic [EXP_W-1:0]    r_cnt;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_out_sign;
    logic [DATA_W-1:0]   r_out_mag;
    logic [EXP_W-1:0]    r_out_exp;
    logic                r_out_sat;

    state_t              w_state_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                w_sign_nxt;
    logic [DATA_W-1:0]   w_mag_nxt;
    logic                w_sat_nxt;
    logic [DATA_W-2:0]   w_shreg_nxt;
    logic [EXP_W-1:0]    w_cnt_nxt;
    logic                w_in_ready_nxt;
    logic                w_out_valid_nxt;
    logic                w_out_sign_nxt;
    logic [DATA_W-1:0]   w_out_mag_nxt;
    logic [EXP_W-1:0]    w_out_exp_nxt;
    logic                w_out_sat_nxt;

    logic                w_cv_sign;
    logic [DATA_W-1:0]   w_cv_mag;
    logic                w_cv_sat;
    logic                w_cv_is_min;

    magnitude_converter #(
        .SAT_NEG    (SAT_NEG)
    ) u_mag_conv (
        .i_data     (r_data),
        .o_sign_c   (w_cv_sign),
        .o_mag_c    (w_cv_mag),
        .o_sat_c    (w_cv_sat),
        .o_is_min_c (w_cv_is_min)
    );

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_sign      <= 1'b0;
            r_mag       <= '0;
            r_sat       <= 1'b0;
            r_shreg     <= '0;
            r_cnt       <= EXP_MAX;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sign  <= 1'b0;
            r_out_mag   <= '0;
            r_out_exp   <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_data      <= w_data_nxt;
            r_sign      <= w_sign_nxt;
            r_mag       <= w_mag_nxt;
            r_sat       <= w_sat_nxt;
            r_shreg     <= w_shreg_nxt;
            r_cnt       <= w_cnt_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_sign  <= w_out_sign_nxt;
            r_out_mag   <= w_out_mag_nxt;
            r_out_exp   <= w_out_exp_nxt;
            r_out_sat   <= w_out_sat_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_data_nxt      = r_data;
        w_sign_nxt      = r_sign;
        w_mag_nxt       = r_mag;
        w_sat_nxt       = r_sat;
        w_shreg_nxt     = r_shreg;
        w_cnt_nxt       = r_cnt;
        w_out_valid_nxt = r_out_valid;
        w_out_sign_nxt  = r_out_sign;
        w_out_mag_nxt   = r_out_mag;
        w_out_exp_nxt   = r_out_exp;
        w_out_sat_nxt   = r_out_sat;

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_data_nxt  = in_data;
                    w_state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                w_sign_nxt  = w_cv_sign;
                w_mag_nxt   = w_cv_mag;
                w_sat_nxt   = w_cv_sat;
                w_shreg_nxt = w_cv_mag[DATA_W-2:0];
                w_cnt_nxt   = EXP_MAX;
                // Unsaturated 0x800 has its leading one at bit 11, outside the scan window
                if (!SAT_NEG && w_cv_is_min) begin
                    w_out_sign_nxt  = w_cv_sign;
                    w_out_mag_nxt   = w_cv_mag;
                    w_out_exp_nxt   = EXP_MAX;
                    w_out_sat_nxt   = 1'b0;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = DONE;
                end else begin
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (r_shreg[DATA_W-2] || (r_cnt == '0)) begin
                    w_out_sign_nxt  = r_sign;
                    w_out_mag_nxt   = r_mag;
                    w_out_exp_nxt   = r_cnt;
                    w_out_sat_nxt   = r_sat;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = DONE;
                end else begin
                    w_shreg_nxt = {r_shreg[DATA_W-3:0], 1'b0};
                    w_cnt_nxt   = r_cnt - EXP_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_in_ready_nxt = (w_state_nxt == IDLE);
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sign  = r_out_sign;
    assign out_mag   = r_out_mag;
    assign out_exp   = r_out_exp;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_exponent_scanner.sv
// Bench for exponent_scanner: directed literal cases plus randomized traffic against a behavioural model.
module tb_exponent_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        out_sign;
    logic [11:0] out_mag;
    logic [2:0]  out_exp;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready;

    logic [11:0] in_data0;
    logic        in_valid0;
    logic        in_ready0;
    logic        out_sign0;
    logic [11:0] out_mag0;
    logic [2:0]  out_exp0;
    logic        out_sat0;
    logic        out_valid0;
    logic        out_ready0;

    always #5 clk = ~clk;

    exponent_scanner #(.SAT_NEG(1'b1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_sign(out_sign), .out_mag(out_mag), .out_exp(out_exp), .out_sat(out_sat),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    exponent_scanner #(.SAT_NEG(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
        .out_sign(out_sign0), .out_mag(out_mag0), .out_exp(out_exp0), .out_sat(out_sat0),
        .out_valid(out_valid0), .out_ready(out_ready0)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Behavioural reference: absolute value, leading-one position, latency from the exponent
    typedef struct {
        logic [11:0] mag;
        logic [2:0]  e;
        logic        sign;
        logic        sat;
        int          lat;
    } res_t;

    typedef struct {
        res_t r;
        int   rise;
    } pend_t;

    function automatic res_t ref_conv(input logic [11:0] d, input bit satneg);
        res_t r;
        int   v;
        int   p;
        int   e;
        v      = $signed(d);
        r.sign = d[11];
        r.sat  = 1'b0;
        if (v < 0) v = -v;
        if (v == 2048 && satneg) begin
            v     = 2047;
            r.sat = 1'b1;
        end
        r.mag = 12'(v);
        p = -1;
        for (int b = 0; b < 12; b++) if (v >= (1 << b)) p = b;
        e = p - 3;
        if (e < 0) e = 0;
        if (e > 7) e = 7;
        r.e   = 3'(e);
        r.lat = (v == 2048) ? 2 : 10 - e;
        return r;
    endfunction

    pend_t q[$];
    int    cyc      = 0;
    bit    last_rst = 1'b0;
    bit    chk_en   = 1'b0;
    bit    was_empty;
    pend_t np;

    // Model update on each active edge
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            last_rst = 1'b1;
        end else begin
            last_rst  = 1'b0;
            was_empty = (q.size() == 0);
            if (!was_empty && cyc >= q[0].rise && out_ready) void'(q.pop_front());
            if (was_empty && in_valid) begin
                np.r    = ref_conv(in_data, 1'b1);
                np.rise = cyc + np.r.lat;
                q.push_back(np);
            end
        end
        cyc++;
    end

    // Compare DUT against model every cycle on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            if (last_rst) begin
                chk("rst_out_valid", 32'(out_valid), 0);
                chk("rst_in_ready",  32'(in_ready),  1);
                chk("rst_out_sign",  32'(out_sign),  0);
                chk("rst_out_mag",   32'(out_mag),   0);
                chk("rst_out_exp",   32'(out_exp),   0);
                chk("rst_out_sat",   32'(out_sat),   0);
            end else begin
                automatic bit ev = (q.size() != 0) && (cyc >= q[0].rise);
                chk("m_in_ready",  32'(in_ready),  32'(q.size() == 0));
                chk("m_out_valid", 32'(out_valid), 32'(ev));
                if (ev) begin
                    chk("m_out_sign", 32'(out_sign), 32'(q[0].r.sign));
                    chk("m_out_mag",  32'(out_mag),  32'(q[0].r.mag));
                    chk("m_out_exp",  32'(out_exp),  32'(q[0].r.e));
                    chk("m_out_sat",  32'(out_sat),  32'(q[0].r.sat));
                end
            end
        end
    end

    bit          sel = 1'b0;
    logic        s_valid, s_sign, s_sat, s_in_ready;
    logic [11:0] s_mag;
    logic [2:0]  s_exp;
    assign s_valid    = sel ? out_valid0 : out_valid;
    assign s_sign     = sel ? out_sign0  : out_sign;
    assign s_sat      = sel ? out_sat0   : out_sat;
    assign s_mag      = sel ? out_mag0   : out_mag;
    assign s_exp      = sel ? out_exp0   : out_exp;
    assign s_in_ready = sel ? in_ready0  : in_ready;

    // Drive one sample (called just after an edge, downstream ready), check literal results and latency
    task automatic run_one(input bit which, input logic [11:0] d, input logic [11:0] m,
                           input logic [2:0] e, input logic s, input logic st, input int lat);
        int n;
        sel = which;
        if (which) begin in_data0 = d; in_valid0 = 1'b1; out_ready0 = 1'b1; end
        else       begin in_data  = d; in_valid  = 1'b1; out_ready  = 1'b1; end
        @(posedge clk); #1;
        if (which) begin in_valid0 = 1'b0; in_data0 = 12'($urandom); end
        else       begin in_valid  = 1'b0; in_data  = 12'($urandom); end
        n = 1;
        while (!s_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("lat_%h", d),  32'(n), 32'(lat));
        chk($sformatf("sign_%h", d), 32'(s_sign), 32'(s));
        chk($sformatf("mag_%h", d),  32'(s_mag), 32'(m));
        chk($sformatf("exp_%h", d),  32'(s_exp), 32'(e));
        chk($sformatf("sat_%h", d),  32'(s_sat), 32'(st));
        @(posedge clk); #1;
        chk($sformatf("drop_%h", d),  32'(s_valid), 0);
        chk($sformatf("ready_%h", d), 32'(s_in_ready), 1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_done", 32'(q.size()), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst0_out_valid", 32'(out_valid0), 0);
        chk("rst0_in_ready",  32'(in_ready0),  1);
        chk("rst0_out_mag",   32'(out_mag0),   0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_one(0, 12'h7FF, 12'h7FF, 3'd7, 1'b0, 1'b0, 3);
        run_one(0, 12'h000, 12'h000, 3'd0, 1'b0, 1'b0, 10);
        run_one(0, 12'hFF0, 12'h010, 3'd1, 1'b1, 1'b0, 9);
        run_one(0, 12'h008, 12'h008, 3'd0, 1'b0, 1'b0, 10);
        run_one(0, 12'h800, 12'h7FF, 3'd7, 1'b1, 1'b1, 3);
        run_one(1, 12'h800, 12'h800, 3'd7, 1'b1, 1'b0, 2);
        run_one(1, 12'h7FF, 12'h7FF, 3'd7, 1'b0, 1'b0, 3);
        run_one(1, 12'hFF0, 12'h010, 3'd1, 1'b1, 1'b0, 9);
        sel = 1'b0;

        // Backpressure: result held, a waiting sample is ignored until the cycle after out_ready
        out_ready = 1'b0; in_data = 12'h0A5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = 12'h123;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_lat", 32'(n), 6);
        for (int i = 0; i < 5; i++) begin
            chk("bp_mag",      32'(out_mag),   32'h0A5);
            chk("bp_exp",      32'(out_exp),   4);
            chk("bp_valid",    32'(out_valid), 1);
            chk("bp_in_ready", 32'(in_ready),  0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(out_valid), 0);
        chk("bp_release_ready", 32'(in_ready),  1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_next_accepted", 32'(in_ready), 0);
        drain();

        // Reset during the fourth scan cycle discards the transaction
        in_data = 12'h001; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rs_out_valid", 32'(out_valid), 0);
        chk("rs_in_ready",  32'(in_ready),  1);
        chk("rs_out_mag",   32'(out_mag),   0);
        chk("rs_out_exp",   32'(out_exp),   0);
        run_one(0, 12'h100, 12'h100, 3'd5, 1'b0, 1'b0, 5);

        // Randomized traffic, backpressure and occasional reset, checked by the model
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 7))
                0:       in_data = 12'h800;
                1:       in_data = 12'h000;
                2:       in_data = 12'($urandom_range(0, 15));
                3:       in_data = 12'h7FF;
                4:       in_data = 12'hFFF - 12'($urandom_range(0, 15));
                default: in_data = 12'($urandom);
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 499) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst = 1'b0; out_ready = 1'b1;
        drain();
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
